id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline boundary directly downstream of the instruction decoder/controller.
- Latches the decoder's control word, register operands, immediate, register indices and PC+4 into the EX stage.
- Detects load-use hazards and generates the stall that freezes PC and IF/ID.
- Inserts bubbles on stall/flush and counts inserted bubbles for the debug unit.

Parameters:
NB_DATA, 32, operand/immediate/PC width
NB_REG, 5, register index width
NB_CTRL, 21, packed control word width (fixed by package layout)
NB_CNT, 16, bubble counter width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  debug-unit step/run enable; 0 freezes the stage
i_flush  in  1  branch/jump taken, kill the instruction in ID
i_id_ctrl  in  NB_CTRL  packed decoder outputs (layout in package)
i_id_rs_data  in  NB_DATA  register-file read port A
i_id_rt_data  in  NB_DATA  register-file read port B
i_id_imm  in  NB_DATA  sign-extended immediate
i_id_pc4  in  NB_DATA  PC+4 of the ID instruction
i_id_rs  in  NB_REG  rs index
i_id_rt  in  NB_REG  rt index
i_id_rd  in  NB_REG  rd index
o_ex_ctrl  out  NB_CTRL  registered control word
o_ex_rs_data  out  NB_DATA  registered operand A
o_ex_rt_data  out  NB_DATA  registered operand B
o_ex_imm  out  NB_DATA  registered immediate
o_ex_pc4  out  NB_DATA  registered PC+4
o_ex_rs  out  NB_REG  registered rs
o_ex_rt  out  NB_REG  registered rt
o_ex_rd  out  NB_REG  registered rd
o_ex_valid  out  1  1 = EX holds a real instruction, 0 = bubble
o_stall  out  1  load-use stall request to PC and IF/ID (combinational)
o_bubble_cnt  out  NB_CNT  saturating count of inserted bubbles

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset: all o_ex_* = 0, o_ex_valid = 0, o_bubble_cnt = 0. An all-zero control word is a NOP: no Reg_write, no Mem_write, no branch or jump.
- Hazard (combinational):
  - o_stall = o_ex_valid & Mem_read(o_ex_ctrl) & (o_ex_rt != 0) & ((o_ex_rt == i_id_rs) | (o_ex_rt == i_id_rt)).
  - o_stall is gated to 0 when i_enable = 0.
- Per rising edge, priority from highest to lowest:
  1. i_enable = 0: hold all registers, including the counter.
  2. i_flush = 1: load bubble (ctrl = 0, valid = 0, data and index fields = 0); counter += 1. Flush wins over a simultaneous stall.
  3. o_stall = 1: load bubble; counter += 1. The ID instruction is held upstream and re-presented next cycle.
  4. Otherwise: load all i_id_* fields; valid = 1.
- Latency: exactly 1 cycle from ID inputs to o_ex_*.
- A stall lasts exactly one cycle. After the bubble, o_ex_valid = 0, so o_stall deasserts.
- o_bubble_cnt saturates at all-ones with no wrap.
- Reset asserted mid-stall: outputs clear immediately (asynchronous); o_stall drops because o_ex_valid = 0.
- No combinational path from i_id_* to o_ex_*. o_stall's only combinational inputs are i_id_rs, i_id_rt and i_enable.

Decomposition:
- Shared package holds:
  - Opcode/funct constants.
  - NB_CTRL = 21.
  - Control-word field offsets, MSB to LSB: Reg_write[20], ALU_source[19], Mem_write[18], ALU_op[17:15], Data_to_Reg[14:13], Mem_read[12], BEQ_flag[11], BNE_flag[10], Jump_flag[9], Reg_dst[8:7], Select_Addr[6:5], Size_control[4:0].
  - Pack/unpack functions.
- One sub-module: load_use_detector (pure combinational stall equation), reused later by the forwarding unit.

Test Plan:
- Reset: assert i_rst_n = 0 mid-cycle with random inputs -> all outputs 0 immediately; o_stall = 0.
- Pass-through: enable = 1, Addi ctrl (Reg_write = 1, ALU_source = 1, ALU_op = 001), rs = 3, rt = 4, imm = 0x0000_0010 -> next cycle o_ex_* match inputs, o_ex_valid = 1, o_stall = 0.
- Load-use: cycle N loads Lw with rt = 5; cycle N+1 ID presents rs = 5 -> o_stall = 1 in N+1; N+2 EX is a bubble with counter = 1; N+3 EX holds the dependent instruction.
- rt = 0 and mismatch: Lw with rt = 0 followed by rs = 0 -> o_stall = 0. Lw with rt = 7 followed by rs = 6, rt = 8 -> o_stall = 0.
- Flush with simultaneous stall: load-use condition plus i_flush = 1 -> single bubble, counter += 1 (not 2).
- Enable hold: i_enable = 0 for 3 cycles during a load-use condition -> outputs and counter frozen, o_stall = 0. On re-enable the stall occurs once. Also preload counter near max and verify it saturates at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared decoder/ID-EX definitions: opcode constants, control-word layout,
// and pack/unpack helpers for the 21-bit control word.
package id_ex_stage_reg_pkg;

  // Opcode and funct constants used by the decoder feeding this stage
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  localparam int CTRL_W = 21;

  // Bit offsets of each field inside the packed control word
  localparam int REG_WRITE_B = 20;
  localparam int ALU_SRC_B   = 19;
  localparam int MEM_WRITE_B = 18;
  localparam int ALU_OP_HI   = 17;
  localparam int ALU_OP_LO   = 15;
  localparam int DTR_HI      = 14;
  localparam int DTR_LO      = 13;
  localparam int MEM_READ_B  = 12;
  localparam int BEQ_B       = 11;
  localparam int BNE_B       = 10;
  localparam int JUMP_B      = 9;
  localparam int REG_DST_HI  = 8;
  localparam int REG_DST_LO  = 7;
  localparam int SEL_ADDR_HI = 6;
  localparam int SEL_ADDR_LO = 5;
  localparam int SIZE_HI     = 4;
  localparam int SIZE_LO     = 0;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [2:0] alu_op;
    logic [1:0] data_to_reg;
    logic       mem_read;
    logic       beq;
    logic       bne;
    logic       jump;
    logic [1:0] reg_dst;
    logic [1:0] sel_addr;
    logic [4:0] size_ctrl;
  } ctrl_t;

  // All-zero control word: no register write, no memory access, no branch
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_t c);
    return c;
  endfunction

  function automatic ctrl_t unpack_ctrl(input logic [CTRL_W-1:0] w);
    return ctrl_t'(w);
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// Load-use hazard equation: a load in EX whose destination is read by the
// instruction in ID must stall one cycle. Pure combinational.
module load_use_detector #(
  parameter int REG_W = 5
) (
  input  logic             i_enable,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  output logic             o_stall
);

  assign o_stall = i_enable & i_ex_valid & i_ex_mem_read & (|i_ex_rt) &
                   ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on flush/stall, and a saturating bubble counter for the debug unit.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic [DATA_W-1:0] i_id_rs_data,
  input  logic [DATA_W-1:0] i_id_rt_data,
  input  logic [DATA_W-1:0] i_id_imm,
  input  logic [DATA_W-1:0] i_id_pc4,
  input  logic [REG_W-1:0]  i_id_rs,
  input  logic [REG_W-1:0]  i_id_rt,
  input  logic [REG_W-1:0]  i_id_rd,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic [DATA_W-1:0] o_ex_rs_data,
  output logic [DATA_W-1:0] o_ex_rt_data,
  output logic [DATA_W-1:0] o_ex_imm,
  output logic [DATA_W-1:0] o_ex_pc4,
  output logic [REG_W-1:0]  o_ex_rs,
  output logic [REG_W-1:0]  o_ex_rt,
  output logic [REG_W-1:0]  o_ex_rd,
  output logic              o_ex_valid,
  output logic              o_stall,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ID side (p0): next contents of the EX register
  logic [CTRL_W-1:0]        ctrl_p0;
  logic [DATA_W-1:0]        rs_data_p0;
  logic [DATA_W-1:0]        rt_data_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic [DATA_W-1:0]        pc4_p0;
  logic [REG_W-1:0]         rs_p0;
  logic [REG_W-1:0]         rt_p0;
  logic [REG_W-1:0]         rd_p0;
  logic                     vld_p0;
  logic [CNT_W-1:0]         bubble_cnt_nxt;

  // EX side (p1): registered stage contents
  logic [CTRL_W-1:0]        ctrl_p1;
  logic [DATA_W-1:0]        rs_data_p1;
  logic [DATA_W-1:0]        rt_data_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0]        pc4_p1;
  logic [REG_W-1:0]         rs_p1;
  logic [REG_W-1:0]         rt_p1;
  logic [REG_W-1:0]         rd_p1;
  logic                     vld_p1;
  logic [CNT_W-1:0]         bubble_cnt;

  logic stall;

  load_use_detector #(
    .REG_W(REG_W)
  ) u_load_use_detector (
    .i_enable      (i_enable),
    .i_ex_valid    (vld_p1),
    .i_ex_mem_read (ctrl_p1[MEM_READ_B]),
    .i_ex_rt       (rt_p1),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .o_stall       (stall)
  );

  always_comb begin
    ctrl_p0        = ctrl_p1;
    rs_data_p0     = rs_data_p1;
    rt_data_p0     = rt_data_p1;
    imm_p0         = imm_p1;
    pc4_p0         = pc4_p1;
    rs_p0          = rs_p1;
    rt_p0          = rt_p1;
    rd_p0          = rd_p1;
    vld_p0         = vld_p1;
    bubble_cnt_nxt = bubble_cnt;
    if (i_enable) begin
      if (i_flush || stall) begin
        ctrl_p0        = CTRL_NOP;
        rs_data_p0     = '0;
        rt_data_p0     = '0;
        imm_p0         = '0;
        pc4_p0         = '0;
        rs_p0          = '0;
        rt_p0          = '0;
        rd_p0          = '0;
        vld_p0         = 1'b0;
        bubble_cnt_nxt = sat_inc(bubble_cnt);
      end else begin
        ctrl_p0    = i_id_ctrl;
        rs_data_p0 = i_id_rs_data;
        rt_data_p0 = i_id_rt_data;
        imm_p0     = i_id_imm;
        pc4_p0     = i_id_pc4;
        rs_p0      = i_id_rs;
        rt_p0      = i_id_rt;
        rd_p0      = i_id_rd;
        vld_p0     = 1'b1;
      end
    end
  end

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_p1    <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      pc4_p1     <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
      vld_p1     <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      ctrl_p1    <= ctrl_p0;
      rs_data_p1 <= rs_data_p0;
      rt_data_p1 <= rt_data_p0;
      imm_p1     <= imm_p0;
      pc4_p1     <= pc4_p0;
      rs_p1      <= rs_p0;
      rt_p1      <= rt_p0;
      rd_p1      <= rd_p0;
      vld_p1     <= vld_p0;
      bubble_cnt <= bubble_cnt_nxt;
    end
  end

  assign o_ex_ctrl    = ctrl_p1;
  assign o_ex_rs_data = rs_data_p1;
  assign o_ex_rt_data = rt_data_p1;
  assign o_ex_imm     = imm_p1;
  assign o_ex_pc4     = pc4_p1;
  assign o_ex_rs      = rs_p1;
  assign o_ex_rt      = rt_p1;
  assign o_ex_rd      = rd_p1;
  assign o_ex_valid   = vld_p1;
  assign o_stall      = stall;
  assign o_bubble_cnt = bubble_cnt;

endmodule
